// File: rtl/codix_probe_tracer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | codix_probe_tracer                                                         |
// | Captures register-file write probes into a timestamped FWFT trace FIFO.   |
// | Revision: 1.0 - initial release                                            |
// +----------------------------------------------------------------------------+
module codix_probe_tracer #(
  parameter int NCH     = 2,
  parameter int AW      = 5,
  parameter int DW      = 32,
  parameter int DEPTH   = 16,
  parameter int TSW     = 16,
  parameter int TIMEOUT = 1024
) (
  input  logic                                   CLK,
  input  logic                                   RST,
  input  logic [NCH-1:0]                         wr_en,
  input  logic [NCH*AW-1:0]                      wr_addr,
  input  logic [NCH*DW-1:0]                      wr_data,
  input  logic                                   halt_act,
  input  logic                                   clr,
  input  logic                                   rd_pop,
  output logic                                   rd_valid,
  output logic [((NCH > 1) ? $clog2(NCH) : 1)-1:0] rd_ch,
  output logic [AW-1:0]                          rd_addr,
  output logic [DW-1:0]                          rd_data,
  output logic [TSW-1:0]                         rd_ts,
  output logic [$clog2(DEPTH):0]                 count,
  output logic [7:0]                             drop_cnt,
  output logic                                   overflow,
  output logic                                   halted,
  output logic                                   timeout
);

  localparam int c_cw = (NCH > 1) ? $clog2(NCH) : 1;
  localparam int c_pw = $clog2(DEPTH);
  localparam int c_ww = $clog2(TIMEOUT + 1);
  localparam int c_ew = c_cw + AW + DW + TSW;

  localparam logic [0:0] c_st_run    = 1'b0;
  localparam logic [0:0] c_st_halted = 1'b1;

  logic [0:0]      r_state;
  logic [0:0]      w_state_next;
  logic [TSW-1:0]  r_ts;
  logic [c_pw-1:0] r_wptr;
  logic [c_pw-1:0] r_rptr;
  logic [c_pw:0]   r_count;
  logic [7:0]      r_drop;
  logic            r_ovf;
  logic            r_to;
  logic [c_ww-1:0] r_wd;
  logic [c_ew-1:0] r_mem [DEPTH];

  logic            w_run;
  logic            w_cand;
  logic [c_cw-1:0] w_cand_ch;
  logic [AW-1:0]   w_cand_addr;
  logic [DW-1:0]   w_cand_data;
  logic [3:0]      w_nen;
  logic            w_full;
  logic            w_push;
  logic            w_pop;
  logic            w_lost_ovf;
  logic [3:0]      w_lost;
  logic [8:0]      w_drop_sum;
  logic [7:0]      w_drop_next;
  logic [c_ww-1:0] w_wd_next;
  logic [c_ew-1:0] w_head;

  // Descending scan so the lowest set channel is the last one assigned.
  always_comb begin
    w_cand      = 1'b0;
    w_cand_ch   = '0;
    w_cand_addr = '0;
    w_cand_data = '0;
    w_nen       = '0;
    for (int i = NCH - 1; i >= 0; i--) begin
      if (wr_en[i]) begin
        w_cand      = 1'b1;
        w_cand_ch   = c_cw'(i);
        w_cand_addr = wr_addr[i*AW +: AW];
        w_cand_data = wr_data[i*DW +: DW];
      end
    end
    for (int i = 0; i < NCH; i++) begin
      w_nen = w_nen + 4'(wr_en[i]);
    end
  end

  assign w_run      = (r_state == c_st_run);
  assign w_full     = (r_count == (c_pw+1)'(DEPTH));
  assign w_pop      = rd_pop & (r_count != '0);
  assign w_push     = w_run & w_cand & (~w_full | rd_pop);
  assign w_lost_ovf = w_run & w_cand & w_full & ~rd_pop;
  assign w_lost     = w_run ? (w_nen - {3'b000, w_cand}) + {3'b000, w_lost_ovf} : 4'd0;
  assign w_drop_sum = {1'b0, r_drop} + {5'b00000, w_lost};
  assign w_drop_next = w_drop_sum[8] ? 8'hFF : w_drop_sum[7:0];
  assign w_wd_next  = (|wr_en) ? '0 : r_wd + 1'b1;

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_state <= c_st_run;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    if (clr) begin
      w_state_next = c_st_run;
    end else begin
      case (r_state)
        c_st_run:    if (halt_act) w_state_next = c_st_halted;
        c_st_halted: w_state_next = c_st_halted;
        default:     w_state_next = c_st_run;
      endcase
    end
  end

  always_comb begin
    halted = (r_state == c_st_halted);
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_ts    <= '0;
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
      r_drop  <= '0;
      r_ovf   <= 1'b0;
      r_to    <= 1'b0;
      r_wd    <= '0;
    end else begin
      r_ts <= r_ts + 1'b1;
      if (clr) begin
        r_wptr  <= '0;
        r_rptr  <= '0;
        r_count <= '0;
        r_drop  <= '0;
        r_ovf   <= 1'b0;
        r_to    <= 1'b0;
        r_wd    <= '0;
      end else begin
        if (w_push) r_wptr <= r_wptr + 1'b1;
        if (w_pop)  r_rptr <= r_rptr + 1'b1;
        case ({w_push, w_pop})
          2'b10:   r_count <= r_count + 1'b1;
          2'b01:   r_count <= r_count - 1'b1;
          default: r_count <= r_count;
        endcase
        r_drop <= w_drop_next;
        if (w_lost_ovf) r_ovf <= 1'b1;
        // Watchdog freezes once expired so its value stays observable until clr.
        if (w_run && !r_to) begin
          r_wd <= w_wd_next;
          if (w_wd_next == c_ww'(TIMEOUT)) r_to <= 1'b1;
        end
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (w_push && !clr) begin
      r_mem[r_wptr] <= {w_cand_ch, w_cand_addr, w_cand_data, r_ts};
    end
  end

  assign w_head = r_mem[r_rptr];

  always_comb begin
    rd_ch   = '0;
    rd_addr = '0;
    rd_data = '0;
    rd_ts   = '0;
    if (r_count != '0) begin
      {rd_ch, rd_addr, rd_data, rd_ts} = w_head;
    end
  end

  assign rd_valid = (r_count != '0);
  assign count    = r_count;
  assign drop_cnt = r_drop;
  assign overflow = r_ovf;
  assign timeout  = r_to;

endmodule
`default_nettype wire

// File: tb/tb_codix_probe_tracer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_codix_probe_tracer                                                      |
// | Scoreboard bench with a queue-based reference model of the trace FIFO.    |
// | Revision: 1.0 - initial release                                            |
// +----------------------------------------------------------------------------+
module tb_codix_probe_tracer;

  localparam int NCH     = 2;
  localparam int AW      = 5;
  localparam int DW      = 32;
  localparam int DEPTH   = 16;
  localparam int TSW     = 16;
  localparam int TIMEOUT = 8;

  logic              CLK;
  logic              RST;
  logic [NCH-1:0]    wr_en;
  logic [NCH*AW-1:0] wr_addr;
  logic [NCH*DW-1:0] wr_data;
  logic              halt_act;
  logic              clr;
  logic              rd_pop;
  logic              rd_valid;
  logic [0:0]        rd_ch;
  logic [AW-1:0]     rd_addr;
  logic [DW-1:0]     rd_data;
  logic [TSW-1:0]    rd_ts;
  logic [4:0]        count;
  logic [7:0]        drop_cnt;
  logic              overflow;
  logic              halted;
  logic              timeout;

  codix_probe_tracer #(
    .NCH(NCH), .AW(AW), .DW(DW), .DEPTH(DEPTH), .TSW(TSW), .TIMEOUT(TIMEOUT)
  ) dut (
    .CLK(CLK), .RST(RST), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .halt_act(halt_act), .clr(clr), .rd_pop(rd_pop), .rd_valid(rd_valid),
    .rd_ch(rd_ch), .rd_addr(rd_addr), .rd_data(rd_data), .rd_ts(rd_ts),
    .count(count), .drop_cnt(drop_cnt), .overflow(overflow), .halted(halted),
    .timeout(timeout)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  typedef struct {
    int          ch;
    logic [31:0] addr;
    logic [31:0] data;
    logic [31:0] ts;
  } ent_t;

  ent_t sb[$];
  int   n_checks = 0;
  int   n_err    = 0;
  bit   mon_en   = 1'b0;

  int   m_cnt, m_drop, m_wd, m_ts;
  bit   m_ovf, m_to, m_halt;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: applies the inputs sampled at the edge just taken.
  task automatic model_step();
    int   n, lo, lost;
    bit   push;
    ent_t e;
    if (clr) begin
      m_cnt = 0; sb.delete(); m_drop = 0; m_ovf = 0; m_to = 0; m_wd = 0; m_halt = 0;
    end else begin
      n = 0; lo = -1; lost = 0; push = 0;
      if (!m_halt) begin
        for (int i = 0; i < NCH; i++) begin
          if (wr_en[i]) begin
            n++;
            if (lo < 0) lo = i;
          end
        end
      end
      if (n > 0) begin
        lost = n - 1;
        if (m_cnt < DEPTH || rd_pop) push = 1;
        else begin
          lost++;
          m_ovf = 1;
        end
      end
      if (rd_pop && m_cnt > 0) m_cnt--;
      if (push) begin
        e.ch   = lo;
        e.addr = 32'(wr_addr[lo*AW +: AW]);
        e.data = wr_data[lo*DW +: DW];
        e.ts   = 32'(m_ts);
        sb.push_back(e);
        m_cnt++;
      end
      m_drop = (m_drop + lost > 255) ? 255 : m_drop + lost;
      if (!m_halt && !m_to) begin
        if (n > 0) m_wd = 0;
        else m_wd++;
        if (m_wd == TIMEOUT) m_to = 1;
      end
      if (!m_halt && halt_act) m_halt = 1;
    end
    m_ts = (m_ts + 1) % (1 << TSW);
  endtask

  task automatic cycle();
    @(posedge CLK);
    #2;
    model_step();
  endtask

  task automatic do_reset();
    mon_en = 1'b0;
    #1 RST = 1'b0;
    #1;
    chk("rst_count", 64'(count), 64'd0);
    chk("rst_valid", 64'(rd_valid), 64'd0);
    chk("rst_drop", 64'(drop_cnt), 64'd0);
    chk("rst_flags", {overflow, halted, timeout}, 64'd0);
    chk("rst_rd", {rd_ch, rd_addr, rd_data, rd_ts}, 64'd0);
    m_cnt = 0; m_drop = 0; m_wd = 0; m_ts = 0; m_ovf = 0; m_to = 0; m_halt = 0;
    sb.delete();
    wr_en = '0; clr = 1'b0; halt_act = 1'b0; rd_pop = 1'b0;
    @(posedge CLK);
    @(posedge CLK);
    #2;
    RST = 1'b1;
    mon_en = 1'b1;
  endtask

  // Monitor: status against the model, head against the scoreboard.
  always @(negedge CLK) begin
    if (mon_en && RST) begin
      chk("count", 64'(count), 64'(m_cnt));
      chk("rd_valid", 64'(rd_valid), 64'(m_cnt != 0));
      chk("drop_cnt", 64'(drop_cnt), 64'(m_drop));
      chk("overflow", 64'(overflow), 64'(m_ovf));
      chk("halted", 64'(halted), 64'(m_halt));
      chk("timeout", 64'(timeout), 64'(m_to));
      if (sb.size() > 0) begin
        chk("head_ch", 64'(rd_ch), 64'(sb[0].ch));
        chk("head_addr", 64'(rd_addr), 64'(sb[0].addr));
        chk("head_data", 64'(rd_data), 64'(sb[0].data));
        chk("head_ts", 64'(rd_ts), 64'(sb[0].ts));
        if (rd_pop && !clr) void'(sb.pop_front());
      end else begin
        chk("empty_rd", {rd_ch, rd_addr, rd_data, rd_ts}, 64'd0);
      end
    end
  end

  initial begin
    RST = 1'b0; wr_en = '0; wr_addr = '0; wr_data = '0;
    halt_act = 1'b0; clr = 1'b0; rd_pop = 1'b0;
    do_reset();

    // Single capture at timestamp 5.
    repeat (5) cycle();
    wr_en = 2'b01; wr_addr = {5'd9, 5'd3}; wr_data = {32'h11111111, 32'hDEADBEEF};
    cycle();
    wr_en = '0;
    chk("t1_valid", 64'(rd_valid), 64'd1);
    chk("t1_ch", 64'(rd_ch), 64'd0);
    chk("t1_addr", 64'(rd_addr), 64'd3);
    chk("t1_data", 64'(rd_data), 64'hDEADBEEF);
    chk("t1_ts", 64'(rd_ts), 64'd5);

    // Simultaneous writes: ch0 wins, ch1 is dropped.
    clr = 1'b1; cycle(); clr = 1'b0;
    wr_en = 2'b11; wr_addr = {5'd7, 5'd2}; wr_data = {32'hAAAA0001, 32'h5555_0000};
    cycle();
    wr_en = '0;
    chk("t2_drop", 64'(drop_cnt), 64'd1);
    chk("t2_ovf", 64'(overflow), 64'd0);
    chk("t2_count", 64'(count), 64'd1);
    chk("t2_ch", 64'(rd_ch), 64'd0);

    // Fill past full, then push with simultaneous pop.
    clr = 1'b1; cycle(); clr = 1'b0;
    for (int k = 0; k < 17; k++) begin
      wr_en = 2'b01; wr_addr = 10'($urandom); wr_data = {$urandom, $urandom};
      cycle();
    end
    chk("t3_count", 64'(count), 64'd16);
    chk("t3_ovf", 64'(overflow), 64'd1);
    chk("t3_drop", 64'(drop_cnt), 64'd1);
    rd_pop = 1'b1; wr_data = {$urandom, $urandom};
    cycle();
    rd_pop = 1'b0; wr_en = '0;
    chk("t3_count_pp", 64'(count), 64'd16);
    chk("t3_drop_pp", 64'(drop_cnt), 64'd1);

    // Halt in the same cycle as a ch1 write.
    clr = 1'b1; cycle(); clr = 1'b0;
    wr_en = 2'b10; halt_act = 1'b1; wr_addr = {5'd17, 5'd0}; wr_data = {32'hCAFEF00D, 32'h0};
    cycle();
    halt_act = 1'b0;
    chk("t4_halted", 64'(halted), 64'd1);
    chk("t4_count", 64'(count), 64'd1);
    chk("t4_ch", 64'(rd_ch), 64'd1);
    wr_en = 2'b11;
    repeat (3) cycle();
    chk("t4_ignored", 64'(count), 64'd1);
    wr_en = '0; clr = 1'b1; cycle(); clr = 1'b0;
    chk("t4_clr_halted", 64'(halted), 64'd0);
    chk("t4_clr_count", 64'(count), 64'd0);

    // Watchdog fires exactly TIMEOUT idle cycles after reset release.
    do_reset();
    repeat (TIMEOUT - 1) cycle();
    chk("t5_not_yet", 64'(timeout), 64'd0);
    cycle();
    chk("t5_fired", 64'(timeout), 64'd1);
    wr_en = 2'b11; repeat (3) cycle(); wr_en = '0;
    chk("t5_sticky", 64'(timeout), 64'd1);
    clr = 1'b1; cycle(); clr = 1'b0;
    chk("t5_clr", 64'(timeout), 64'd0);

    // Asynchronous reset with entries pending.
    wr_en = 2'b01;
    repeat (5) cycle();
    wr_en = '0;
    chk("t6_count", 64'(count), 64'd5);
    do_reset();

    // Randomized traffic, alternating drain-heavy and fill-heavy phases.
    for (int k = 0; k < 3000; k++) begin
      wr_en    = 2'($urandom);
      wr_addr  = 10'($urandom);
      wr_data  = {$urandom, $urandom};
      halt_act = ($urandom % 100) < 3;
      clr      = ($urandom % 100) < 2;
      rd_pop   = ((k / 200) % 2 == 0) ? (($urandom % 100) < 70) : (($urandom % 100) < 15);
      if ($urandom % 1000 == 0) do_reset();
      else cycle();
    end
    wr_en = '0; clr = 1'b0; halt_act = 1'b0; rd_pop = 1'b0;
    cycle();
    @(negedge CLK);
    #1;
    mon_en = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/codix_probe_tracer.md
CODIX_PROBE_TRACER -- requirements
Module: codix_probe_tracer

Interface
REQ-001 SHALL have parameter NCH, default 2: number of register-write probe channels, 1..8.
REQ-002 SHALL have parameter AW, default 5: probe write-address width.
REQ-003 SHALL have parameter DW, default 32: probe write-data width.
REQ-004 SHALL have parameter DEPTH, default 16: trace FIFO entries, power of two, 2..256.
REQ-005 SHALL have parameter TSW, default 16: timestamp width.
REQ-006 SHALL have parameter TIMEOUT, default 1024: idle cycles before the watchdog fires, at least 1.
REQ-007 SHALL have port CLK, input, 1 bit: the single clock; all state updates on the rising edge.
REQ-008 SHALL have port RST, input, 1 bit: reset, asynchronous, active-low.
REQ-009 SHALL have port wr_en, input, NCH bits: per-channel register-file write enable (WE0 probe).
REQ-010 SHALL have port wr_addr, input, NCH*AW bits: per-channel write address; channel i uses slice [i*AW +: AW].
REQ-011 SHALL have port wr_data, input, NCH*DW bits: per-channel write data; channel i uses slice [i*DW +: DW].
REQ-012 SHALL have port halt_act, input, 1 bit: halt functional-unit activity probe.
REQ-013 SHALL have port clr, input, 1 bit: synchronous flush and clear.
REQ-014 SHALL have port rd_pop, input, 1 bit: consume the FIFO head.
REQ-015 SHALL have port rd_valid, output, 1 bit: FIFO not empty.
REQ-016 SHALL have port rd_ch, output, max(1,$clog2(NCH)) bits: head channel index.
REQ-017 SHALL have port rd_addr, output, AW bits: head address.
REQ-018 SHALL have port rd_data, output, DW bits: head data.
REQ-019 SHALL have port rd_ts, output, TSW bits: head timestamp.
REQ-020 SHALL have port count, output, $clog2(DEPTH)+1 bits: FIFO occupancy.
REQ-021 SHALL have port drop_cnt, output, 8 bits: dropped-event count, saturating.
REQ-022 SHALL have port overflow, output, 1 bit: sticky; an event was lost because the FIFO was full.
REQ-023 SHALL have port halted, output, 1 bit: the FSM is in HALTED.
REQ-024 SHALL have port timeout, output, 1 bit: sticky; the watchdog expired.

Function
REQ-025 SHALL run a free-running TSW-bit timestamp counter that increments every cycle and wraps from 2^TSW-1 to 0.
REQ-026 SHALL implement a two-state FSM:
- RUN -> HALTED when halt_act=1.
- HALTED -> RUN only on clr.
REQ-027 SHALL, in RUN, select per cycle the lowest-index channel with wr_en set as the capture candidate.
REQ-028 SHALL capture in the same cycle halt_act is first sampled, so a candidate present that cycle is still captured.
REQ-029 SHALL ignore all wr_en in HALTED.
REQ-030 SHALL, for each non-selected channel with wr_en set in RUN, count one dropped event in drop_cnt.
- Dropped channels SHALL NOT set overflow.
REQ-031 SHALL push {channel, addr, data, current timestamp} for the candidate when the FIFO is not full, or when full and rd_pop=1 in the same cycle (pop-then-push, count unchanged).
REQ-032 SHALL, when the FIFO is full, rd_pop=0 and a candidate exists, drop the candidate, set overflow, and add 1 to drop_cnt.
REQ-033 SHALL increase drop_cnt by the total number of events lost in a cycle, saturating at 255.
REQ-034 SHALL provide first-word-fall-through output:
- rd_* show the head combinationally from FIFO storage.
- rd_valid = (count != 0).
- A pushed entry is visible the cycle after its push.
REQ-035 SHALL ignore rd_pop when count = 0.
- Pointers wrap modulo DEPTH.
REQ-036 SHALL run an idle watchdog:
- Reset to 0 on any wr_en bit in RUN; otherwise increment in RUN.
- Set timeout when it reaches TIMEOUT.
- Hold its value in HALTED or once timeout is set.
REQ-037 SHALL, on clr, empty the FIFO and clear overflow, timeout, drop_cnt, the watchdog and the FSM (to RUN).
- clr SHALL override push and pop in the same cycle.
- clr SHALL NOT reset the timestamp.
REQ-038 SHALL drive rd_ch, rd_addr, rd_data and rd_ts to 0 whenever count = 0.

Reset
REQ-039 SHALL, while RST=0, asynchronously force the following, and resume on the first edge after RST returns to 1:
- FSM to RUN.
- count, pointers, timestamp, watchdog and drop_cnt to 0.
- rd_valid, overflow, halted and timeout to 0.
- rd_* outputs to 0.
REQ-040 SHALL discard all FIFO contents on a reset asserted mid-operation; contents are not recovered.

Verification
REQ-041 SHALL cover: NCH=2, ch0 writes addr 3, data 0xDEADBEEF at timestamp 5 -> next cycle rd_valid=1, rd_ch=0, rd_addr=3, rd_data=0xDEADBEEF, rd_ts=5.
REQ-042 SHALL cover: both channels write in the same cycle -> only ch0 is captured, drop_cnt=1, overflow=0.
REQ-043 SHALL cover: DEPTH=16, 17 writes with no pop -> count=16, overflow=1, drop_cnt=1; then a write with rd_pop in the same cycle -> count=16, drop_cnt unchanged.
REQ-044 SHALL cover: halt_act pulse in the same cycle as a ch1 write -> that write is captured, halted=1, later writes are ignored; clr -> halted=0, count=0.
REQ-045 SHALL cover: TIMEOUT=8 with no writes -> timeout=1 exactly 8 cycles after reset release; it stays set through later writes until clr.
REQ-046 SHALL cover: RST asserted with count=5 -> count=0 and rd_valid=0 immediately, with no clock edge required.
